// File: rtl/coeff_loader.sv
// Coefficient loader: packs host bytes into DEPTH-bit words and writes WORDS of them to the
// coefficient memory. Define COEFF_LOADER_VERIFY_EN to add XOR-checksum readback verification.
module coeff_loader #(
  parameter  int DEPTH = 24,
  parameter  int WORDS = 8,
  localparam int AW    = $clog2(WORDS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             in_valid_i,
  input  logic [7:0]       in_data_i,
  output logic             in_ready_o,
  output logic             mem_ce_o,
  output logic             mem_we_o,
  output logic [AW-1:0]    mem_a_o,
  output logic [DEPTH-1:0] mem_d_o,
  input  logic [DEPTH-1:0] mem_q_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o
);

  localparam int BPW = (DEPTH + 7) / 8;
  localparam int SW  = 8 * BPW;
  localparam int CW  = $clog2(BPW + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_READ, S_DRAIN, S_CHECK
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    shift_q, shift_d;
  logic             in_ready_q, in_ready_d;
  logic             ce_q, ce_d;
  logic             we_q, we_d;
  logic [AW-1:0]    mem_a_q, mem_a_d;
  logic [DEPTH-1:0] mem_d_q, mem_d_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic accept, last_byte, last_addr, start_ok;

  assign accept    = in_ready_q && in_valid_i;
  assign last_byte = (cnt_q == CW'(BPW - 1));
  assign last_addr = (addr_q == AW'(WORDS - 1));
  // CHECK already reports busy=0, so a start arriving there is honoured.
  assign start_ok  = start_i && (state_q == S_IDLE || state_q == S_CHECK);

`ifdef COEFF_LOADER_VERIFY_EN
  logic [DEPTH-1:0] checksum_q, checksum_d;
  logic [DEPTH-1:0] readback_q, readback_d;
  logic             rd_valid_q, rd_valid_d;
  logic             error_q, error_d;
`else
  logic             unused_mem_q;
  assign unused_mem_q = ^mem_q_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      in_ready_q <= 1'b0;
      ce_q       <= 1'b0;
      we_q       <= 1'b0;
      mem_a_q    <= '0;
      mem_d_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef COEFF_LOADER_VERIFY_EN
      checksum_q <= '0;
      readback_q <= '0;
      rd_valid_q <= 1'b0;
      error_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      in_ready_q <= in_ready_d;
      ce_q       <= ce_d;
      we_q       <= we_d;
      mem_a_q    <= mem_a_d;
      mem_d_q    <= mem_d_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef COEFF_LOADER_VERIFY_EN
      checksum_q <= checksum_d;
      readback_q <= readback_d;
      rd_valid_q <= rd_valid_d;
      error_q    <= error_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_CHECK: state_d = start_ok ? S_LOAD : S_IDLE;
      S_LOAD:          if (accept && last_byte) state_d = S_WRITE;
      S_WRITE: begin
        if (last_addr) begin
`ifdef COEFF_LOADER_VERIFY_EN
          state_d = S_READ;
`else
          state_d = S_IDLE;
`endif
        end else begin
          state_d = S_LOAD;
        end
      end
      S_READ:          if (last_addr) state_d = S_DRAIN;
      S_DRAIN:         state_d = S_CHECK;
      default:         state_d = S_IDLE;
    endcase
  end

  // Outputs are registered, so their next values are derived from state_d.
  always_comb begin
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    mem_d_d = mem_d_q;
    if (start_ok) begin
      addr_d  = '0;
      cnt_d   = '0;
      shift_d = '0;
    end
    if (accept) begin
      shift_d = (shift_q << 8) | SW'(in_data_i);
      cnt_d   = last_byte ? '0 : cnt_q + CW'(1);
      if (last_byte) mem_d_d = shift_d[DEPTH-1:0];
    end
    if (state_q == S_WRITE || state_q == S_READ) begin
      addr_d = last_addr ? '0 : addr_q + AW'(1);
    end

    in_ready_d = (state_d == S_LOAD);
    ce_d       = (state_d == S_WRITE) || (state_d == S_READ);
`ifdef COEFF_LOADER_VERIFY_EN
    we_d       = (state_d == S_WRITE);
`else
    we_d       = ce_d;
`endif
    mem_a_d    = ce_d ? addr_d : '0;
    busy_d     = (state_d == S_LOAD) || (state_d == S_WRITE) ||
                 (state_d == S_READ) || (state_d == S_DRAIN);
    done_d     = (state_q == S_WRITE && state_d == S_IDLE) || (state_d == S_CHECK);

`ifdef COEFF_LOADER_VERIFY_EN
    checksum_d = checksum_q;
    readback_d = readback_q;
    error_d    = error_q;
    rd_valid_d = ce_q && !we_q;
    if (state_q == S_WRITE) checksum_d = checksum_q ^ mem_d_q;
    if (rd_valid_q)         readback_d = readback_q ^ mem_q_i;
    if (start_ok) begin
      checksum_d = '0;
      readback_d = '0;
      error_d    = 1'b0;
    end
    if (state_d == S_CHECK) error_d = (readback_d != checksum_q);
`endif
  end

  assign in_ready_o = in_ready_q;
  assign mem_ce_o   = ce_q;
  assign mem_we_o   = we_q;
  assign mem_a_o    = mem_a_q;
  assign mem_d_o    = mem_d_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
`ifdef COEFF_LOADER_VERIFY_EN
  assign error_o    = error_q;
`else
  assign error_o    = 1'b0;
`endif

endmodule
